// File: rtl/tour_cmd_if.sv
// Command path between the UART wrapper, the tour replay block and cmd_proc.
// The slave modport is the replay block's view of that path.
interface tour_cmd_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport slave (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output cmd, cmd_rdy, resp
    );

    modport master (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd.sv
// Knight-tour replay: passes UART commands through when idle, otherwise splits each
// stored one-hot knight move into two straight-line legs. Option macro: TOUR_FANFARE_EN.
module tour_cmd #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    tour_cmd_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE1 = 3'd1,
        WAIT1 = 3'd2,
        MOVE2 = 3'd3,
        WAIT2 = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);
    localparam logic [7:0]       RESP_DONE = 8'hA5;
    localparam logic [7:0]       RESP_BUSY = 8'h5A;

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] LEG2_OP = 4'h5;
`else
    localparam logic [3:0] LEG2_OP = 4'h4;
`endif

    // First leg is the two-square run; anything not one-hot becomes a zero-length move.
    function automatic logic [15:0] leg1(input logic [7:0] m);
        logic [15:0] c;
        case (m)
            8'h01:   c = 16'h4002;
            8'h02:   c = 16'h4002;
            8'h04:   c = 16'h43F2;
            8'h08:   c = 16'h43F2;
            8'h10:   c = 16'h47F2;
            8'h20:   c = 16'h47F2;
            8'h40:   c = 16'h4BF2;
            8'h80:   c = 16'h4BF2;
            default: c = 16'h4000;
        endcase
        return c;
    endfunction

    // Second leg is the single-square sidestep, carrying the optional fanfare opcode.
    function automatic logic [15:0] leg2(input logic [7:0] m);
        logic [15:0] c;
        case (m)
            8'h01:   c = {LEG2_OP, 12'hBF1};
            8'h02:   c = {LEG2_OP, 12'h3F1};
            8'h04:   c = {LEG2_OP, 12'h001};
            8'h08:   c = {LEG2_OP, 12'h7F1};
            8'h10:   c = {LEG2_OP, 12'h3F1};
            8'h20:   c = {LEG2_OP, 12'hBF1};
            8'h40:   c = {LEG2_OP, 12'h7F1};
            8'h80:   c = {LEG2_OP, 12'h001};
            default: c = 16'h4000;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cmd_s;
    logic             cmd_rdy_s;
    logic [7:0]       resp_s;

    // State and move-index registers; reset aborts any tour in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic and command mux; the WAIT states hold the leg while cmd_proc executes it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_s     = leg1(move);
        cmd_rdy_s = 1'b0;
        resp_s    = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd_s     = bus.cmd_UART;
                cmd_rdy_s = bus.cmd_rdy_UART;
                resp_s    = RESP_DONE;
                if (start_tour) begin
                    idx_d   = '0;
                    state_d = MOVE1;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE1: begin
                cmd_rdy_s = 1'b1;
                if (bus.clr_cmd_rdy) begin
                    state_d = WAIT1;
                end else begin
                    state_d = MOVE1;
                end
            end
            WAIT1: begin
                if (bus.send_resp) begin
                    state_d = MOVE2;
                end else begin
                    state_d = WAIT1;
                end
            end
            MOVE2: begin
                cmd_s     = leg2(move);
                cmd_rdy_s = 1'b1;
                if (bus.clr_cmd_rdy) begin
                    state_d = WAIT2;
                end else begin
                    state_d = MOVE2;
                end
            end
            WAIT2: begin
                cmd_s = leg2(move);
                if (idx_q == LAST_IDX) begin
                    resp_s = RESP_DONE;
                end else begin
                    resp_s = RESP_BUSY;
                end
                if (bus.send_resp && (idx_q == LAST_IDX)) begin
                    state_d = IDLE;
                end else if (bus.send_resp) begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = MOVE1;
                end else begin
                    state_d = WAIT2;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.cmd     = cmd_s;
    assign bus.cmd_rdy = cmd_rdy_s;
    assign bus.resp    = resp_s;
    assign mv_indx     = idx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed self-checking bench for tour_cmd: pass-through, leg table, full tour,
// mid-tour reset and ignored start_tour.
module tb_tour_cmd;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_tour;
    logic [7:0] move;
    logic [4:0] mv_indx;
    logic [7:0] store [24];

    int errors = 0;
    int checks = 0;

    logic [15:0] l1_tab [8] = '{16'h4002, 16'h4002, 16'h43F2, 16'h43F2,
                                16'h47F2, 16'h47F2, 16'h4BF2, 16'h4BF2};
`ifdef TOUR_FANFARE_EN
    logic [15:0] l2_tab [8] = '{16'h5BF1, 16'h53F1, 16'h5001, 16'h57F1,
                                16'h53F1, 16'h5BF1, 16'h57F1, 16'h5001};
`else
    logic [15:0] l2_tab [8] = '{16'h4BF1, 16'h43F1, 16'h4001, 16'h47F1,
                                16'h43F1, 16'h4BF1, 16'h47F1, 16'h4001};
`endif

    tour_cmd_if bus ();

    tour_cmd #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    always_comb move = store[mv_indx];

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_tour = 1'b1;
        @(negedge clk); start_tour = 1'b0;
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk); bus.clr_cmd_rdy = 1'b1;
        @(negedge clk); bus.clr_cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic pulse_resp();
        @(negedge clk); bus.send_resp = 1'b1;
        @(negedge clk); bus.send_resp = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1;
        do_reset();
        if (mv_indx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", mv_indx); end
        checks++;
        if (bus.resp !== 8'hA5) begin errors++; $display("FAIL reset_resp: got %h expected a5", bus.resp); end
        checks++;
        if (bus.cmd !== 16'h1234) begin errors++; $display("FAIL pass_cmd: got %h expected 1234", bus.cmd); end
        checks++;
        if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL pass_rdy: got %b expected 1", bus.cmd_rdy); end
        checks++;
    endtask

    task automatic test_passthrough();
        @(negedge clk); bus.cmd_UART = 16'hBEEF; bus.cmd_rdy_UART = 1'b0; #1;
        if (bus.cmd !== 16'hBEEF) begin errors++; $display("FAIL pass_cmd2: got %h expected beef", bus.cmd); end
        checks++;
        if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL pass_rdy2: got %b expected 0", bus.cmd_rdy); end
        checks++;
    endtask

    task automatic test_first_moves();
        store[0] = 8'h01; store[1] = 8'h02; store[2] = 8'h04;
        do_reset();
        pulse_start();
        if (bus.cmd !== 16'h4002 || bus.cmd_rdy !== 1'b1) begin errors++;
            $display("FAIL m0_leg1: got %h/%b expected 4002/1", bus.cmd, bus.cmd_rdy); end
        checks++;
        pulse_clr();
        if (bus.cmd !== 16'h4002 || bus.cmd_rdy !== 1'b0) begin errors++;
            $display("FAIL m0_wait1: got %h/%b expected 4002/0", bus.cmd, bus.cmd_rdy); end
        checks++;
        if (bus.resp !== 8'h5A) begin errors++; $display("FAIL m0_resp: got %h expected 5a", bus.resp); end
        checks++;
        pulse_resp();
        if (bus.cmd !== 16'h4BF1 || bus.cmd_rdy !== 1'b1) begin errors++;
            $display("FAIL m0_leg2: got %h/%b expected 4bf1/1", bus.cmd, bus.cmd_rdy); end
        checks++;
        pulse_clr();
        pulse_resp();
        if (mv_indx !== 5'd1 || bus.cmd !== 16'h4002) begin errors++;
            $display("FAIL m1_leg1: got idx %0d cmd %h expected 1/4002", mv_indx, bus.cmd); end
        checks++;
        pulse_clr(); pulse_resp();
        if (bus.cmd !== 16'h43F1) begin errors++; $display("FAIL m1_leg2: got %h expected 43f1", bus.cmd); end
        checks++;
        pulse_clr(); pulse_resp();
        if (mv_indx !== 5'd2 || bus.cmd !== 16'h43F2) begin errors++;
            $display("FAIL m2_leg1: got idx %0d cmd %h expected 2/43f2", mv_indx, bus.cmd); end
        checks++;
        pulse_clr(); pulse_resp();
        if (bus.cmd !== 16'h4001 || bus.resp !== 8'h5A) begin errors++;
            $display("FAIL m2_leg2: got %h/%h expected 4001/5a", bus.cmd, bus.resp); end
        checks++;
    endtask

    task automatic test_leg_table();
        logic [7:0]  mv;
        logic [15:0] e1, e2;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                mv = 8'h01 << k; e1 = l1_tab[k]; e2 = l2_tab[k];
            end else begin
                mv = 8'h03; e1 = 16'h4000; e2 = 16'h4000;
            end
            store[0] = mv;
            do_reset();
            pulse_start();
            if (bus.cmd !== e1) begin errors++;
                $display("FAIL leg1_tab: move %h got %h expected %h", mv, bus.cmd, e1); end
            checks++;
            pulse_clr(); pulse_resp();
            if (bus.cmd !== e2 || bus.cmd_rdy !== 1'b1) begin errors++;
                $display("FAIL leg2_tab: move %h got %h/%b expected %h/1", mv, bus.cmd, bus.cmd_rdy, e2); end
            checks++;
        end
    endtask

    task automatic test_full_tour();
        logic [7:0] one;
        one = 8'h01;
        for (int i = 0; i < 24; i++) store[i] = one << (i % 8);
        bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            if (mv_indx !== 5'(i) || bus.cmd !== l1_tab[i % 8] || bus.cmd_rdy !== 1'b1) begin errors++;
                $display("FAIL tour_leg1: i=%0d got idx %0d cmd %h rdy %b expected %0d/%h/1",
                         i, mv_indx, bus.cmd, bus.cmd_rdy, i, l1_tab[i % 8]); end
            checks++;
            pulse_clr(); pulse_resp();
            if (bus.cmd !== l2_tab[i % 8] || bus.resp !== 8'h5A) begin errors++;
                $display("FAIL tour_leg2: i=%0d got %h/%h expected %h/5a", i, bus.cmd, bus.resp, l2_tab[i % 8]); end
            checks++;
            pulse_clr();
            if (bus.resp !== ((i == 23) ? 8'hA5 : 8'h5A) || bus.cmd_rdy !== 1'b0) begin errors++;
                $display("FAIL tour_wait2: i=%0d got resp %h rdy %b", i, bus.resp, bus.cmd_rdy); end
            checks++;
            pulse_resp();
        end
        if (bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin errors++;
            $display("FAIL tour_end: got %h/%b/%h expected 1234/1/a5", bus.cmd, bus.cmd_rdy, bus.resp); end
        checks++;
        if (mv_indx !== 5'd23) begin errors++; $display("FAIL tour_end_idx: got %0d expected 23", mv_indx); end
        checks++;
    endtask

    task automatic test_mid_tour();
        bus.cmd_UART = 16'h7777; bus.cmd_rdy_UART = 1'b0;
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            pulse_clr(); pulse_resp(); pulse_clr(); pulse_resp();
        end
        pulse_clr();
        if (mv_indx !== 5'd5 || bus.cmd_rdy !== 1'b0) begin errors++;
            $display("FAIL wait1_idx5: got %0d/%b expected 5/0", mv_indx, bus.cmd_rdy); end
        checks++;
        bus.cmd_rdy_UART = 1'b1;
        pulse_start();
        if (mv_indx !== 5'd5 || bus.cmd_rdy !== 1'b0 || bus.cmd !== l1_tab[5]) begin errors++;
            $display("FAIL start_ignored: got %0d/%b/%h expected 5/0/%h", mv_indx, bus.cmd_rdy, bus.cmd, l1_tab[5]); end
        checks++;
        do_reset();
        if (mv_indx !== 5'd0 || bus.cmd !== 16'h7777 || bus.resp !== 8'hA5) begin errors++;
            $display("FAIL mid_reset: got %0d/%h/%h expected 0/7777/a5", mv_indx, bus.cmd, bus.resp); end
        checks++;
    endtask

    initial begin
        rst = 1'b1; start_tour = 1'b0;
        bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        bus.cmd_UART = 16'h0000; bus.cmd_rdy_UART = 1'b0;
        for (int i = 0; i < 24; i++) store[i] = 8'h00;
        test_reset();
        test_passthrough();
        test_first_moves();
        test_leg_table();
        test_full_tour();
        test_mid_tour();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Sits between the UART command path and cmd_proc in the knight-tour robot.
- When idle, it passes UART commands straight through to cmd_proc.
- After a solved tour is signalled (start_tour), it takes over the command path. It replays the stored move sequence, splitting each one-hot knight move into two straight-line move commands, and handshakes each command with cmd_proc.

Parameters:
- NUM_MOVES, 24: number of moves in a tour. The last index is NUM_MOVES-1.
- IDX_W, 5: width of mv_indx.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_tour  in  1  single-cycle pulse from tour logic: the solution is ready.
- move  in  8  one-hot knight move read at address mv_indx.
- mv_indx  out  IDX_W  index of the current move; addresses the move store.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  command-ready from the UART wrapper.
- cmd  out  16  multiplexed command to cmd_proc.
- cmd_rdy  out  1  command-ready to cmd_proc.
- clr_cmd_rdy  in  1  cmd_proc has accepted the current command.
- send_resp  in  1  cmd_proc has finished executing the command.
- resp  out  8  response byte: 8'hA5 = done, 8'h5A = in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE, mv_indx = 0. Reset mid-tour aborts immediately to the same condition.
- State machine: IDLE, MOVE1, WAIT1, MOVE2, WAIT2. Registered state; cmd, cmd_rdy and resp are combinational from state and inputs.
- IDLE:
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART.
  - start_tour: mv_indx <= 0, go to MOVE1.
- MOVE1:
  - cmd = LEG1(move), cmd_rdy = 1.
  - clr_cmd_rdy: go to WAIT1.
  - send_resp in this state is ignored.
- WAIT1:
  - cmd = LEG1 (held), cmd_rdy = 0.
  - send_resp: go to MOVE2.
- MOVE2:
  - cmd = LEG2(move), cmd_rdy = 1.
  - clr_cmd_rdy: go to WAIT2.
- WAIT2:
  - cmd = LEG2 (held), cmd_rdy = 0.
  - send_resp with mv_indx == NUM_MOVES-1: go to IDLE.
  - send_resp otherwise: mv_indx <= mv_indx+1, go to MOVE1.
- start_tour outside IDLE is ignored. UART inputs are ignored outside IDLE.
- Latency: cmd_rdy is high in the cycle after the start_tour edge. With start_tour pulsed at one negedge, cmd is valid by the next negedge.
- resp = 8'hA5 in IDLE, or in WAIT2 when mv_indx == NUM_MOVES-1. Otherwise resp = 8'h5A.
- Command format:
  - [15:12] opcode, 4'h4 = move.
  - [11:4] heading: 8'h00 north, 8'h3F west, 8'h7F south, 8'hBF east.
  - [3:0] number of squares.
- Leg table, given as move bit: LEG1 / LEG2:
  - bit0: 4002 / 4BF1
  - bit1: 4002 / 43F1
  - bit2: 43F2 / 4001
  - bit3: 43F2 / 47F1
  - bit4: 47F2 / 43F1
  - bit5: 47F2 / 4BF1
  - bit6: 4BF2 / 47F1
  - bit7: 4BF2 / 4001
- A move value that is not one-hot gives LEG1 = LEG2 = 16'h4000 (zero squares). The handshake sequence is unchanged.
- mv_indx never exceeds NUM_MOVES-1; there is no wrap during a tour.

Optional Feature:
- Macro: TOUR_FANFARE_EN.
- Defined: LEG2 opcode is 4'h5 (move with fanfare), e.g. bit0 gives LEG2 = 16'h5BF1. LEG1 is unchanged.
- Undefined: all legs use opcode 4'h4, exactly as in the leg table.

Test Plan:
- Reset, then cmd_UART = 16'h1234, cmd_rdy_UART = 1 -> cmd = 1234, cmd_rdy = 1, resp = A5, mv_indx = 0.
- Move store [0]=01, [1]=02, [2]=04. Pulse start_tour -> MOVE1 with cmd = 4002, cmd_rdy = 1. Pulse clr_cmd_rdy -> cmd stays 4002, cmd_rdy = 0. Pulse send_resp -> cmd = 4BF1. Pulse clr_cmd_rdy, then send_resp -> mv_indx = 1, cmd = 4002. Second leg -> 43F1. Index 2 -> 43F2 then 4001. resp = 5A throughout.
- All 8 move bits, plus move = 8'h03 -> every leg matches the leg table; 8'h03 gives 4000 / 4000.
- Run the full 24-move tour -> on the final send_resp the block returns to IDLE, resp goes from 5A (A5 in final WAIT2) to A5, and cmd reverts to cmd_UART.
- Assert rst while in WAIT1 at mv_indx = 5 -> next cycle IDLE, mv_indx = 0. start_tour asserted mid-tour -> no effect.
- With TOUR_FANFARE_EN defined, move = 01 -> 4002 then 5BF1.
